// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule definitions: FSM states, round constants, S-box table and
// word-level helpers used by the key expansion datapath.
package aes_pkg;

  localparam int unsigned DATA_WIDTH = 128;
  localparam int unsigned NUM_RK     = 15;
  localparam int unsigned IDX_WIDTH  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoadLo,
    StExpand
  } state_e;

  // Entry 0 is unused so the table is indexed directly by i/2.
  localparam logic [7:0] RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  // Entry 0 sits in the MSBs; entry n starts at bit (255-n)*8.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = {~b, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Each new word is the same-position word of the key two steps back XORed with its
  // left neighbour in the new key; w0 takes the transformed temp instead.
  function automatic logic [127:0] xor_chain(input logic [127:0] prev, input logic [31:0] temp);
    logic [31:0] w0, w1, w2, w3;
    w0 = prev[127:96] ^ temp;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/mod_subword.sv
// AES SubWord: byte-wise S-box substitution of a 32-bit word, purely combinational.
module mod_subword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign o_word[8*g +: 8] = sbox(i_word[8*g +: 8]);
  end

endmodule

// File: rtl/mod_keyexpansion.sv
// Iterative AES-256 key schedule: takes the cipher key as two 128-bit beats and streams
// rk0..rk14, one round key per handshake, holding under consumer backpressure.
module mod_keyexpansion
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] key_data,
  input  logic                  key_valid,
  output logic                  key_ready,
  output logic [DATA_WIDTH-1:0] rk_data,
  output logic [IDX_WIDTH-1:0]  rk_idx,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic                  busy,
  output logic                  done
);

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_prev2;
  logic [DATA_WIDTH-1:0] r_prev1;
  logic [DATA_WIDTH-1:0] r_rk_data;
  logic [IDX_WIDTH-1:0]  r_rk_idx;
  logic                  r_rk_valid;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_beat_acc;
  logic                  w_rk_hs;
  logic [IDX_WIDTH-1:0]  w_next_idx;
  logic                  w_even;
  logic [31:0]           w_sub_in;
  logic [31:0]           w_sub_out;
  logic [31:0]           w_temp;
  logic [DATA_WIDTH-1:0] w_next_rk;

  // The low beat may land in the same cycle rk0 is taken, keeping the stream gapless.
  always_comb begin
    key_ready = 1'b0;
    unique case (r_state)
      StIdle:   key_ready = 1'b1;
      StLoadLo: key_ready = !r_rk_valid || rk_ready;
      StExpand: key_ready = 1'b0;
      default:  key_ready = 1'b0;
    endcase
  end

  assign w_beat_acc = key_valid && key_ready;
  assign w_rk_hs    = r_rk_valid && rk_ready;

  // Parity of the key being generated selects the RotWord+Rcon or plain SubWord step.
  assign w_next_idx = r_rk_idx + 4'd1;
  assign w_even     = ~w_next_idx[0];
  assign w_sub_in   = w_even ? rot_word(r_prev1[31:0]) : r_prev1[31:0];

  mod_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  assign w_temp    = w_sub_out ^ (w_even ? {RCON[w_next_idx[3:1]], 24'h000000} : 32'h0);
  assign w_next_rk = xor_chain(r_prev2, w_temp);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_prev2    <= '0;
      r_prev1    <= '0;
      r_rk_data  <= '0;
      r_rk_idx   <= '0;
      r_rk_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_beat_acc) begin
            r_prev2    <= key_data;
            r_rk_data  <= key_data;
            r_rk_idx   <= '0;
            r_rk_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StLoadLo;
          end
        end
        StLoadLo: begin
          if (w_beat_acc) begin
            r_prev1    <= key_data;
            r_rk_data  <= key_data;
            r_rk_idx   <= 4'd1;
            r_rk_valid <= 1'b1;
            r_state    <= StExpand;
          end else if (w_rk_hs) begin
            r_rk_valid <= 1'b0;
          end
        end
        StExpand: begin
          if (w_rk_hs) begin
            if (r_rk_idx == IDX_WIDTH'(NUM_RK - 1)) begin
              r_rk_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= StIdle;
            end else begin
              r_rk_data <= w_next_rk;
              r_rk_idx  <= w_next_idx;
              r_prev2   <= r_prev1;
              r_prev1   <= w_next_rk;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rk_data  = r_rk_data;
  assign rk_idx   = r_rk_idx;
  assign rk_valid = r_rk_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
